// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sysid_checker_pkg;

    // FSM states; RD_TS/WAIT_TS are only reachable when the timestamp check is built in
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } state_t;

    // sysid slave word addresses
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // width of the per-transaction timeout counter
    localparam int TMO_W = 16;

endpackage

// File: rtl/sysid_checker_timeout.sv
// Loadable up-counter with terminal-count compare, bounding one read transaction.
// Latency: expired asserts combinationally from the registered count (LIMIT-th cycle after load).
// Backpressure: none; counts while en is high, load has priority over en.
//
// Ports: clock, reset (sync, active-high), load (clear count to 0), en (increment),
//        expired (this is the last permitted cycle of the transaction).
module sysid_checker_timeout
    import sysid_checker_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    // count is 0 in the first cycle after load, so cycle number LIMIT has count LIMIT-1
    localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMO_W'(1);
        end
    end

    // >= rather than == so a transaction that outlives the limit across a
    // RD->WAIT hand-over still trips (e.g. LIMIT=1 seen first in WAIT_*)
    assign expired = (count >= LAST);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID word (and timestamp) and compares them to build-time values.
// Latency: done pulses 5 sampling edges after start (3 without timestamp check), +1 per waitrequest/readdata cycle.
// Backpressure: holds avm_read/avm_address while avm_waitrequest=1; each read aborts after TIMEOUT_CYCLES.
//
// Ports: clock, reset (sync, active-high); start (pulse, ignored while busy);
//        avm_address/avm_read/avm_waitrequest/avm_readdata/avm_readdatavalid (Avalon-MM read master);
//        busy, done (1-cycle pulse), id_ok, ts_ok, timeout, id_value, ts_value (status, all registered).
// Build option: define SYSID_CHECKER_TS_CHECK_EN to also read and check the timestamp word;
//        otherwise only the ID is read, ts_ok is tied to 1 and ts_value to 0.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1542721402,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t state;
    state_t state_next;
    logic   abort;
    logic   tmo_load;
    logic   tmo_en;
    logic   tmo_expired;
    logic   read_next;
    logic   addr_next;
    logic   busy_next;
    logic   done_next;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // Forward progress wins over expiry when both happen in the same cycle.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RD_ID;
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    state_next = WAIT_ID;
                end else if (tmo_expired) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
            end
            WAIT_ID: begin
                if (avm_readdatavalid) begin
`ifdef SYSID_CHECKER_TS_CHECK_EN
                    state_next = RD_TS;
`else
                    state_next = DONE;
`endif
                end else if (tmo_expired) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
            end
`ifdef SYSID_CHECKER_TS_CHECK_EN
            RD_TS: begin
                if (!avm_waitrequest) begin
                    state_next = WAIT_TS;
                end else if (tmo_expired) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
            end
            WAIT_TS: begin
                if (avm_readdatavalid) begin
                    state_next = DONE;
                end else if (tmo_expired) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Decoded from state_next and registered below, so every output is a flop
    // and nothing on the Avalon side reaches an output combinationally.
    always_comb begin
        read_next = (state_next == RD_ID) || (state_next == RD_TS);
        addr_next = ((state_next == RD_TS) || (state_next == WAIT_TS)) ? ADDR_TS : ADDR_ID;
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            avm_read    <= read_next;
            avm_address <= addr_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    // ---------------- transaction timeout ----------------
    // Restarted on entry to each RD_* state so the limit applies per read.
    assign tmo_load = ((state_next == RD_ID) || (state_next == RD_TS)) && (state_next != state);
    assign tmo_en   = (state == RD_ID) || (state == WAIT_ID) || (state == RD_TS) || (state == WAIT_TS);

    sysid_checker_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // ---------------- result capture ----------------
    // readdatavalid is only honoured in WAIT_*; a late beat in IDLE is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_ok    <= 1'b0;
            id_value <= '0;
            timeout  <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                id_ok    <= 1'b0;
                id_value <= '0;
                timeout  <= 1'b0;
            end
            if ((state == WAIT_ID) && avm_readdatavalid) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (abort) begin
                timeout <= 1'b1;
            end
        end
    end

`ifdef SYSID_CHECKER_TS_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_ok    <= 1'b0;
            ts_value <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                ts_ok    <= 1'b0;
                ts_value <= '0;
            end
            if ((state == WAIT_TS) && avm_readdatavalid) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
        end
    end
`else
    // Timestamp not checked in this build: report it as matching.
    assign ts_ok    = 1'b1;
    assign ts_value = '0;

    logic unused_ts;
    assign unused_ts = ^EXPECTED_TS;
`endif

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that sits directly downstream of the system-ID slave in the SOPC. On a start request it reads the ID word and the build timestamp, compares both against the values expected at synthesis, and reports pass/fail/timeout to the boot and status logic. This lets the counter firmware and the Ethernet path refuse to run against a mismatched FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000, ID word expected at sysid address 0
- EXPECTED_TS, 32'd1542721402, timestamp expected at sysid address 1
- TIMEOUT_CYCLES, 255, max cycles per read transaction before abort (1..65535)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run a check; ignored while busy
- avm_address  out  1  0 = ID word, 1 = timestamp
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; read is accepted on a cycle with avm_read=1 and waitrequest=0
- avm_readdata  in  32  read data, sampled when avm_readdatavalid=1
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of check (pass, fail or timeout)
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TS
- timeout  out  1  last check aborted on timeout
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE: start=1 → RD_ID; clears id_ok, ts_ok, timeout, id_value, ts_value; loads timeout counter with 0.
- RD_ID: avm_read=1, avm_address=0, held stable until waitrequest=0 → WAIT_ID.
- WAIT_ID: avm_read=0; readdatavalid=1 → capture id_value, id_ok = (data == EXPECTED_ID), → RD_TS.
- RD_TS / WAIT_TS: same as RD_ID/WAIT_ID with address 1, capturing ts_value/ts_ok → DONE.
- DONE: done=1 for exactly one cycle → IDLE. Results hold until the next accepted start.
- Timeout counter: 16-bit, cleared on entry to each RD_* state, increments every cycle in RD_*/WAIT_*; reaching TIMEOUT_CYCLES → timeout=1, avm_read=0, → DONE. Flags of the unfinished read stay 0.
- readdatavalid is honoured only in WAIT_* states; it is ignored elsewhere (including the accept cycle).
- start while busy: ignored, no queueing.
- Reset mid-operation: all outputs return to reset values on the same edge; late readdatavalid arriving in IDLE is discarded.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0.
- busy=1 in every state except IDLE.
- Zero waitrequest, readdatavalid one cycle after accept: start sampled at edge N; RD_ID N+1; WAIT_ID N+2; RD_TS N+3; WAIT_TS N+4; done=1 at N+5.
- Each cycle of waitrequest or readdata latency adds one cycle.
- All outputs are registered; no combinational path from Avalon inputs to outputs.

## Configuration
- SYSID_CHECKER_TS_CHECK_EN defined: full sequence as above.
- Not defined: RD_TS/WAIT_TS are removed; WAIT_ID goes directly to DONE; ts_ok is forced to 1 and ts_value to 0. Zero-latency done is at N+3.

## Structure
- Package sysid_checker_pkg: state enum, address constants (ADDR_ID=0, ADDR_TS=1), and the timeout counter width (16).
- One sub-module: sysid_checker_timeout, a loadable up-counter with a terminal-count compare. The FSM and compare logic stay in the top module.

## Test plan
- Matching slave (ID 0, TS 1542721402), zero wait, 1-cycle latency, start pulse → done at N+5, id_ok=1, ts_ok=1, timeout=0.
- Slave returns TS 32'h1234_5678 → done, id_ok=1, ts_ok=0, ts_value=32'h1234_5678.
- waitrequest held for 3 cycles on each read → avm_address/avm_read stable throughout, done at N+11, both ok.
- readdatavalid never asserted, TIMEOUT_CYCLES=8 → timeout=1, id_ok=0, done 8 cycles after entering RD_ID, avm_read low.
- start re-pulsed while busy, then reset asserted in WAIT_TS → second start ignored; after reset all outputs 0, state IDLE, and a late readdatavalid has no effect.
- Macro undefined → only address 0 read, done at N+3, ts_ok=1.
